// File: rtl/fifo_width_upsizer.sv
// Packs RATIO narrow FWFT words into one wide word for a downstream FIFO.
// Define FIFO_UPSIZER_FLUSH_EN to add flush/out_keep partial-word emission.
module fifo_width_upsizer #(
  parameter int IN_WIDTH = 32,
  parameter int RATIO = 2,
  localparam int OUT_WIDTH = IN_WIDTH * RATIO,
  localparam int CNT_WIDTH = (RATIO > 1) ? $clog2(RATIO) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_empty_n,
  output logic                 in_read,
  input  logic [IN_WIDTH-1:0]  in_dout,
  input  logic                 out_full_n,
  output logic                 out_write,
  output logic [OUT_WIDTH-1:0] out_din
`ifdef FIFO_UPSIZER_FLUSH_EN
  ,
  input  logic                 flush,
  output logic [RATIO-1:0]     out_keep
`endif
);

  localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(RATIO - 1);

  logic [CNT_WIDTH-1:0] cnt;
  logic                 out_valid;
  logic [OUT_WIDTH-1:0] out_data;
  logic                 last;
  logic                 stall;
  logic                 accept;
  logic                 drain;
  logic                 complete;
  logic                 emit;
  logic [RATIO-1:0]     fill;
  logic [OUT_WIDTH-1:0] word;
  logic [IN_WIDTH-1:0]  lane_src [RATIO];

  assign last     = (cnt == LAST);
  assign drain    = out_valid & out_full_n;
  assign stall    = last & out_valid & ~out_full_n;
  // Reset gates the handshakes so nothing moves while it is held.
  assign accept   = in_empty_n & ~stall & ~reset;
  assign in_read  = accept;
  assign complete = accept & last;
  assign out_write = out_valid & ~reset;
  assign out_din  = out_data;

`ifdef FIFO_UPSIZER_FLUSH_EN
  logic             flush_go;
  logic [RATIO-1:0] keep_q;

  assign flush_go = flush & ~complete
                  & ((cnt != '0) | accept)
                  & (~out_valid | out_full_n);
  assign emit     = complete | flush_go;
  assign out_keep = keep_q;
`else
  assign emit = complete;
`endif

  genvar g;
  generate
    for (g = 0; g < RATIO; g++) begin : g_pack
      assign fill[g] = (CNT_WIDTH'(g) < cnt)
                     | ((CNT_WIDTH'(g) == cnt) & accept);
      assign word[g*IN_WIDTH +: IN_WIDTH] =
        fill[g] ? lane_src[g] : '0;
    end

    if (RATIO > 1) begin : g_lanes
      logic [IN_WIDTH-1:0] lanes [RATIO-1];

      always_ff @(posedge clk) begin
        for (int i = 0; i < RATIO - 1; i++) begin
          if (reset) begin
            lanes[i] <= '0;
          end else if (accept && cnt == CNT_WIDTH'(i)) begin
            lanes[i] <= in_dout;
          end
        end
      end

      for (genvar h = 0; h < RATIO; h++) begin : g_src
        if (h < RATIO - 1) begin : g_reg
          assign lane_src[h] = lanes[h];
        end else begin : g_top
          assign lane_src[h] = in_dout;
        end
      end
    end else begin : g_pass
      assign lane_src[0] = in_dout;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
`ifdef FIFO_UPSIZER_FLUSH_EN
      keep_q    <= '0;
`endif
    end else begin
      if (emit) begin
        cnt <= '0;
      end else if (accept) begin
        cnt <= cnt + CNT_WIDTH'(1);
      end
      // A new word wins over a drain: back-to-back without a bubble.
      if (emit) begin
        out_valid <= 1'b1;
        out_data  <= word;
`ifdef FIFO_UPSIZER_FLUSH_EN
        keep_q    <= fill;
`endif
      end else if (drain) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fifo_width_upsizer.sv
// Bench for fifo_width_upsizer: a RATIO=2 x32 and a RATIO=4 x8 instance,
// table-driven cycles plus a packing model feeding a scoreboard queue.
module tb_fifo_width_upsizer;

  typedef struct {
    bit          sel;
    bit          rst;
    bit          e;
    bit          f;
    bit          fl;
    logic [31:0] din;
    bit          rd;
    bit          wr;
    logic [63:0] dout;
    logic [3:0]  keep;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic e2, f2, rd2, wr2;
  logic [31:0] d2;
  logic [63:0] q2;
  logic e4, f4, rd4, wr4;
  logic [7:0] d4;
  logic [31:0] q4;
`ifdef FIFO_UPSIZER_FLUSH_EN
  logic fl2, fl4;
  logic [1:0] k2;
  logic [3:0] k4;
`endif

  int total = 0;
  int bad = 0;
  vec_t vecs[$];
  logic [63:0] sb0[$];
  logic [63:0] sb1[$];
  logic [63:0] mw [2];
  int m_n [2];

  always #5 clk = ~clk;

  fifo_width_upsizer #(.IN_WIDTH(32), .RATIO(2)) dut2 (
    .clk(clk), .reset(rst),
    .in_empty_n(e2), .in_read(rd2), .in_dout(d2),
    .out_full_n(f2), .out_write(wr2), .out_din(q2)
`ifdef FIFO_UPSIZER_FLUSH_EN
    , .flush(fl2), .out_keep(k2)
`endif
  );

  fifo_width_upsizer #(.IN_WIDTH(8), .RATIO(4)) dut4 (
    .clk(clk), .reset(rst),
    .in_empty_n(e4), .in_read(rd4), .in_dout(d4),
    .out_full_n(f4), .out_write(wr4), .out_din(q4)
`ifdef FIFO_UPSIZER_FLUSH_EN
    , .flush(fl4), .out_keep(k4)
`endif
  );

  task automatic chk(input string n, input logic [63:0] a,
                     input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h want %h", n, a, e);
    end
  endtask

  function automatic vec_t mk(input bit sel, input bit r, input bit e,
                              input bit f, input bit fl,
                              input logic [31:0] din, input bit rd,
                              input bit wr, input logic [63:0] dout);
    vec_t v;
    v.sel = sel; v.rst = r; v.e = e; v.f = f; v.fl = fl;
    v.din = din; v.rd = rd; v.wr = wr; v.dout = dout;
    v.keep = sel ? 4'hF : 4'h3;
    return v;
  endfunction

  function automatic void add(input bit sel, input bit r, input bit e,
                              input bit f, input logic [31:0] din,
                              input bit rd, input bit wr,
                              input logic [63:0] dout);
    vecs.push_back(mk(sel, r, e, f, 1'b0, din, rd, wr, dout));
  endfunction

  task automatic step(input vec_t v);
    logic        a_rd, a_wr;
    logic [63:0] a_d;
    logic [63:0] exp_w;
    int          s;
    s = v.sel ? 1 : 0;
    rst = v.rst;
    if (v.sel) begin
      e4 = v.e; f4 = v.f; d4 = v.din[7:0];
      e2 = 1'b0; f2 = 1'b1;
    end else begin
      e2 = v.e; f2 = v.f; d2 = v.din;
      e4 = 1'b0; f4 = 1'b1;
    end
`ifdef FIFO_UPSIZER_FLUSH_EN
    fl2 = 1'b0;
    fl4 = v.sel & v.fl;
`endif
    @(negedge clk);
    a_rd = v.sel ? rd4 : rd2;
    a_wr = v.sel ? wr4 : wr2;
    a_d  = v.sel ? {32'h0, q4} : q2;
    chk("in_read", {63'h0, a_rd}, {63'h0, v.rd});
    chk("out_write", {63'h0, a_wr}, {63'h0, v.wr});
    if (v.wr || v.rst) chk("out_din", a_d, v.dout);
`ifdef FIFO_UPSIZER_FLUSH_EN
    if (v.wr)
      chk("out_keep", {60'h0, v.sel ? k4 : {2'b00, k2}},
          {60'h0, v.keep});
`endif
    if (a_wr && v.f) begin
      if ((s ? sb1.size() : sb0.size()) == 0) begin
        chk("sb_unexpected_write", 64'h1, 64'h0);
      end else begin
        exp_w = s ? sb1.pop_front() : sb0.pop_front();
        chk("sb_word", a_d, exp_w);
      end
    end
    if (v.rst) begin
      m_n[0] = 0; m_n[1] = 0;
      mw[0] = '0; mw[1] = '0;
      sb0.delete(); sb1.delete();
    end else begin
      if (v.rd) begin
        if (s == 1) mw[1][m_n[1]*8 +: 8] = v.din[7:0];
        else mw[0][m_n[0]*32 +: 32] = v.din;
        m_n[s]++;
      end
      if (m_n[s] == (s ? 4 : 2) || (v.fl && m_n[s] > 0)) begin
        if (s == 1) sb1.push_back(mw[1]);
        else sb0.push_back(mw[0]);
        mw[s] = '0;
        m_n[s] = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t v;
    rst = 1'b1;
    e2 = 1'b0; f2 = 1'b1; d2 = '0;
    e4 = 1'b0; f4 = 1'b1; d4 = '0;
`ifdef FIFO_UPSIZER_FLUSH_EN
    fl2 = 1'b0; fl4 = 1'b0;
`endif
    m_n[0] = 0; m_n[1] = 0;
    mw[0] = '0; mw[1] = '0;
    @(posedge clk);
    #1;

    // reset held with data waiting
    add(0, 1, 1, 1, 32'h99, 0, 0, 64'h0);
    add(0, 1, 1, 1, 32'h99, 0, 0, 64'h0);
    add(1, 1, 1, 1, 32'h99, 0, 0, 64'h0);
    // streaming, RATIO=2
    add(0, 0, 1, 1, 32'h11, 1, 0, 64'h0);
    add(0, 0, 1, 1, 32'h22, 1, 0, 64'h0);
    add(0, 0, 1, 1, 32'h33, 1, 1, 64'h00000022_00000011);
    add(0, 0, 1, 1, 32'h44, 1, 0, 64'h0);
    add(0, 0, 0, 1, 32'h00, 0, 1, 64'h00000044_00000033);
    add(0, 0, 0, 1, 32'h00, 0, 0, 64'h0);
    // upstream bubbles
    add(0, 0, 1, 1, 32'h55, 1, 0, 64'h0);
    add(0, 0, 0, 1, 32'h66, 0, 0, 64'h0);
    add(0, 0, 0, 1, 32'h66, 0, 0, 64'h0);
    add(0, 0, 1, 1, 32'h77, 1, 0, 64'h0);
    add(0, 0, 0, 1, 32'h00, 0, 1, 64'h00000077_00000055);
    add(0, 0, 0, 1, 32'h00, 0, 0, 64'h0);
    // backpressure, RATIO=4
    add(1, 0, 1, 0, 32'h01, 1, 0, 64'h0);
    add(1, 0, 1, 0, 32'h02, 1, 0, 64'h0);
    add(1, 0, 1, 0, 32'h03, 1, 0, 64'h0);
    add(1, 0, 1, 0, 32'h04, 1, 0, 64'h0);
    add(1, 0, 1, 0, 32'hA1, 1, 1, 64'h04030201);
    add(1, 0, 1, 0, 32'hA2, 1, 1, 64'h04030201);
    add(1, 0, 1, 0, 32'hA3, 1, 1, 64'h04030201);
    add(1, 0, 1, 0, 32'hA4, 0, 1, 64'h04030201);
    add(1, 0, 1, 0, 32'hA4, 0, 1, 64'h04030201);
    add(1, 0, 1, 1, 32'hA4, 1, 1, 64'h04030201);
    add(1, 0, 0, 1, 32'h00, 0, 1, 64'hA4A3A2A1);
    add(1, 0, 0, 1, 32'h00, 0, 0, 64'h0);
    // reset mid-packet
    add(1, 0, 1, 1, 32'hB1, 1, 0, 64'h0);
    add(1, 0, 1, 1, 32'hB2, 1, 0, 64'h0);
    add(1, 1, 1, 1, 32'hB3, 0, 0, 64'hA4A3A2A1);
    add(1, 0, 1, 1, 32'hC1, 1, 0, 64'h0);
    add(1, 0, 1, 1, 32'hC2, 1, 0, 64'h0);
    add(1, 0, 1, 1, 32'hC3, 1, 0, 64'h0);
    add(1, 0, 1, 1, 32'hC4, 1, 0, 64'h0);
    add(1, 0, 0, 1, 32'h00, 0, 1, 64'hC4C3C2C1);
    add(1, 0, 0, 1, 32'h00, 0, 0, 64'h0);

    for (int i = 0; i < vecs.size(); i++) step(vecs[i]);

`ifdef FIFO_UPSIZER_FLUSH_EN
    // partial word flush, then a flush with nothing buffered
    step(mk(1, 0, 1, 1, 0, 32'h0A, 1, 0, 64'h0));
    step(mk(1, 0, 1, 1, 0, 32'h0B, 1, 0, 64'h0));
    step(mk(1, 0, 0, 1, 1, 32'h00, 0, 0, 64'h0));
    v = mk(1, 0, 0, 1, 1, 32'h00, 0, 1, 64'h00000B0A);
    v.keep = 4'h3;
    step(v);
    step(mk(1, 0, 0, 1, 0, 32'h00, 0, 0, 64'h0));
`else
    v = mk(1, 0, 0, 1, 0, 32'h00, 0, 0, 64'h0);
    step(v);
`endif

    chk("sb_left", 64'(sb0.size() + sb1.size()), 64'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
